// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one memory port between imem and dmem
// Zero-latency selection in IDLE; the winner owns the port until m_gnt completes it.
module core_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int STRB_W  = DATA_W / 8,
  parameter int FIRST_D = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,

  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_wen,
  input  logic [STRB_W-1:0] imem_strb,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic              imem_gnt,
  output logic              imem_err,
  output logic [DATA_W-1:0] imem_rdata,

  input  logic              dmem_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_err,
  output logic [DATA_W-1:0] dmem_rdata,

  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wen,
  output logic [STRB_W-1:0] m_strb,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_err,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  localparam logic LAST_D_RST = (FIRST_D == 0);

  owner_e owner_q, owner_d;
  logic   last_d_q, last_d_d;
  logic   sel_i, sel_d;

  // Selection is shared by the next-state and output logic; in IDLE the
  // side that did not go last wins a conflict.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    unique case (owner_q)
      OWN_I: sel_i = 1'b1;
      OWN_D: sel_d = 1'b1;
      default: begin
        sel_d = dmem_req & (~imem_req | ~last_d_q);
        sel_i = imem_req & ~sel_d;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      owner_q  <= IDLE;
      last_d_q <= LAST_D_RST;
    end else begin
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    owner_d  = owner_q;
    last_d_d = last_d_q;
    unique case (owner_q)
      IDLE: begin
        if (sel_i | sel_d) begin
          last_d_d = sel_d;
          if (!m_gnt) owner_d = sel_d ? OWN_D : OWN_I;
        end
      end
      OWN_I, OWN_D: begin
        if (m_gnt) owner_d = IDLE;
      end
      default: owner_d = IDLE;
    endcase
  end

  // Requests are suppressed while reset is held so nothing reaches downstream.
  always_comb begin
    m_req      = g_resetn & (sel_i | sel_d);
    m_addr     = sel_d ? dmem_addr  : imem_addr;
    m_wen      = sel_d ? dmem_wen   : imem_wen;
    m_strb     = sel_d ? dmem_strb  : imem_strb;
    m_wdata    = sel_d ? dmem_wdata : imem_wdata;
    imem_gnt   = m_gnt & m_req & sel_i;
    dmem_gnt   = m_gnt & m_req & sel_d;
    imem_err   = m_err & imem_gnt;
    dmem_err   = m_err & dmem_gnt;
    imem_rdata = m_rdata;
    dmem_rdata = m_rdata;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_gnt, imem_err;
  logic [63:0] imem_addr, imem_wdata, imem_rdata;
  logic [7:0]  imem_strb;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  logic        m_req, m_wen, m_gnt, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_strb;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .FIRST_D(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata), .imem_gnt(imem_gnt),
    .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_err(m_err), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run mid-cycle.
  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_resetn = 1'b0;
    imem_req = 1'b1; imem_addr = 64'h100; imem_wen = 1'b0; imem_strb = 8'h00; imem_wdata = 64'h0;
    dmem_req = 1'b1; dmem_addr = 64'h200; dmem_wen = 1'b0; dmem_strb = 8'h00; dmem_wdata = 64'h0;
    m_gnt = 1'b1; m_err = 1'b1; m_rdata = 64'h0;

    // 1: reset holds everything quiet
    #3;
    chk("rst_m_req", m_req, 0);
    chk("rst_imem_gnt", imem_gnt, 0);
    chk("rst_dmem_gnt", dmem_gnt, 0);
    chk("rst_imem_err", imem_err, 0);
    chk("rst_dmem_err", dmem_err, 0);
    cyc(); cyc();
    g_resetn = 1'b1; m_err = 1'b0;
    #3;
    chk("first_conflict_addr", m_addr, 64'h200);
    chk("first_conflict_dgnt", dmem_gnt, 1);
    chk("first_conflict_ignt", imem_gnt, 0);

    // 2: single-cycle imem read
    cyc();
    dmem_req = 1'b0; imem_addr = 64'h40; m_rdata = 64'hDEAD_BEEF;
    #3;
    chk("rd_m_req", m_req, 1);
    chk("rd_m_addr", m_addr, 64'h40);
    chk("rd_imem_gnt", imem_gnt, 1);
    chk("rd_imem_rdata", imem_rdata, 64'hDEAD_BEEF);
    chk("rd_dmem_gnt", dmem_gnt, 0);
    chk("rd_imem_err", imem_err, 0);
    cyc();
    imem_req = 1'b0; m_gnt = 1'b0; imem_addr = 64'h100;
    #3;
    chk("rd_stays_idle", m_req, 0);

    // 3: continuous contention alternates D,I,D,I...
    cyc();
    imem_req = 1'b1; dmem_req = 1'b1; m_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("rr_dmem_gnt", dmem_gnt, (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_imem_gnt", imem_gnt, (k % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_m_addr", m_addr, (k % 2 == 0) ? 64'h200 : 64'h100);
      cyc();
    end

    // 4: owned dmem write, imem arrives mid-wait, dmem drops req once
    imem_req = 1'b0; m_gnt = 1'b0;
    dmem_addr = 64'h1000; dmem_wen = 1'b1; dmem_strb = 8'hFF; dmem_wdata = 64'h1122_3344_5566_7788;
    #3;
    chk("wr0_m_req", m_req, 1);
    chk("wr0_m_addr", m_addr, 64'h1000);
    chk("wr0_m_wen", m_wen, 1);
    chk("wr0_m_strb", m_strb, 8'hFF);
    chk("wr0_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
    chk("wr0_dmem_gnt", dmem_gnt, 0);
    cyc();
    imem_req = 1'b1; dmem_req = 1'b0;
    #3;
    chk("wr1_m_req_held", m_req, 1);
    chk("wr1_m_addr_held", m_addr, 64'h1000);
    chk("wr1_m_wen_held", m_wen, 1);
    chk("wr1_imem_gnt", imem_gnt, 0);
    cyc();
    dmem_req = 1'b1; m_gnt = 1'b1;
    #3;
    chk("wr2_m_addr", m_addr, 64'h1000);
    chk("wr2_dmem_gnt", dmem_gnt, 1);
    chk("wr2_imem_gnt", imem_gnt, 0);
    cyc();
    dmem_req = 1'b0; dmem_wen = 1'b0; dmem_strb = 8'h00; dmem_addr = 64'h200;
    #3;
    chk("wr3_m_addr", m_addr, 64'h100);
    chk("wr3_imem_gnt", imem_gnt, 1);

    // 5: error routing
    cyc();
    m_err = 1'b1;
    #3;
    chk("err_imem_err", imem_err, 1);
    chk("err_imem_gnt", imem_gnt, 1);
    chk("err_dmem_err", dmem_err, 0);
    cyc();
    imem_req = 1'b0; dmem_req = 1'b1;
    #3;
    chk("err_d_dmem_err", dmem_err, 1);
    chk("err_d_imem_err", imem_err, 0);

    // spurious m_gnt with no request is dropped
    cyc();
    dmem_req = 1'b0; m_err = 1'b0;
    #3;
    chk("spur_imem_gnt", imem_gnt, 0);
    chk("spur_dmem_gnt", dmem_gnt, 0);

    // 6: reset pulse while OWN_I with m_gnt pending
    cyc();
    imem_req = 1'b1; m_gnt = 1'b0;
    cyc();
    dmem_req = 1'b1;
    #3;
    chk("own_i_m_addr", m_addr, 64'h100);
    chk("own_i_m_req", m_req, 1);
    g_resetn = 1'b0; m_gnt = 1'b1;
    #1;
    chk("rst6_m_req", m_req, 0);
    chk("rst6_imem_gnt", imem_gnt, 0);
    cyc();
    g_resetn = 1'b1; m_gnt = 1'b0;
    #3;
    chk("rst6_restart_addr", m_addr, 64'h200);
    m_gnt = 1'b1;
    #1;
    chk("rst6_restart_dgnt", dmem_gnt, 1);
    chk("rst6_restart_ignt", imem_gnt, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
